// File: rtl/bus_load_unit_if.sv
// Bus/control bundle between the datapath and bus_load_unit.
// The master side is the ISDU/datapath driving loads; the slave side is bus_load_unit.
interface bus_load_unit_if;
    logic [15:0] bus;
    logic [15:0] mdr_in;
    logic [15:0] addr_sum;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        LD_IR;
    logic        LD_PC;
    logic        LD_REG;
    logic        LD_CC;
    logic        LD_BEN;
    logic        MIO_EN;
    logic [1:0]  PCMUX;
    logic        DRMUX;
    logic        SR1MUX;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] IR;
    logic [15:0] PC;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic [2:0]  nzp;
    logic        BEN;

    modport master (
        output bus, mdr_in, addr_sum,
        output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
        output MIO_EN, PCMUX, DRMUX, SR1MUX,
        input  MAR, MDR, IR, PC, sr1_out, sr2_out, nzp, BEN
    );

    modport slave (
        input  bus, mdr_in, addr_sum,
        input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
        input  MIO_EN, PCMUX, DRMUX, SR1MUX,
        output MAR, MDR, IR, PC, sr1_out, sr2_out, nzp, BEN
    );
endinterface

// File: rtl/bus_load_unit.sv
// SLC-3 architectural state capture: MAR/MDR/IR/PC, R0-R7, NZP and BEN loaded from the CPU bus.
// Every destination loads independently; reads of the register file are unbypassed.
module bus_load_unit (
    input  logic             Clk,
    input  logic             Reset,
    bus_load_unit_if.slave   bif
);
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic [15:0] ir_q;
    logic [15:0] pc_q;
    logic [15:0] regs_q [8];
    logic [2:0]  nzp_q;
    logic        ben_q;

    logic [15:0] pc_next;
    logic [15:0] mdr_next;
    logic [2:0]  nzp_next;
    logic [2:0]  dr_idx;
    logic [2:0]  sr1_idx;
    logic [7:0]  reg_ld;

    always_comb begin
        pc_next = pc_q;
        case (bif.PCMUX)
            2'b00:   pc_next = pc_q + 16'd1;
            2'b01:   pc_next = bif.bus;
            2'b10:   pc_next = bif.addr_sum;
            default: pc_next = pc_q;
        endcase
    end

    assign mdr_next = bif.MIO_EN ? bif.mdr_in : bif.bus;

    always_comb begin
        nzp_next = 3'b001;
        if (bif.bus[15])
            nzp_next = 3'b100;
        else if (bif.bus == 16'h0000)
            nzp_next = 3'b010;
    end

    // Destination decode uses the IR as it stands before the edge, so LD_IR+LD_REG writes via the old DR.
    assign dr_idx  = bif.DRMUX ? 3'b111 : ir_q[11:9];
    assign sr1_idx = bif.SR1MUX ? ir_q[8:6] : ir_q[11:9];

    always_comb begin
        reg_ld = 8'h00;
        if (bif.LD_REG)
            reg_ld[dr_idx] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
            ir_q  <= 16'h0000;
            pc_q  <= 16'h0000;
            nzp_q <= 3'b000;
            ben_q <= 1'b0;
            for (int i = 0; i < 8; i++)
                regs_q[i] <= 16'h0000;
        end else begin
            if (bif.LD_MAR) mar_q <= bif.bus;
            if (bif.LD_MDR) mdr_q <= mdr_next;
            if (bif.LD_IR)  ir_q  <= bif.bus;
            if (bif.LD_PC)  pc_q  <= pc_next;
            if (bif.LD_CC)  nzp_q <= nzp_next;
            if (bif.LD_BEN) ben_q <= |(ir_q[11:9] & nzp_q);
            for (int i = 0; i < 8; i++)
                if (reg_ld[i]) regs_q[i] <= bif.bus;
        end
    end

    assign bif.MAR     = mar_q;
    assign bif.MDR     = mdr_q;
    assign bif.IR      = ir_q;
    assign bif.PC      = pc_q;
    assign bif.nzp     = nzp_q;
    assign bif.BEN     = ben_q;
    assign bif.sr1_out = regs_q[sr1_idx];
    assign bif.sr2_out = regs_q[ir_q[2:0]];
endmodule

// File: tb/tb_bus_load_unit.sv
// Directed bench for bus_load_unit; expected values are hand-computed and a small register-file model.
module tb_bus_load_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [15:0] exp_reg [8];

    bus_load_unit_if bif ();

    bus_load_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bif   (bif)
    );

    always #5 Clk = ~Clk;

    task automatic clear_ctrl();
        bif.LD_MAR = 1'b0;
        bif.LD_MDR = 1'b0;
        bif.LD_IR  = 1'b0;
        bif.LD_PC  = 1'b0;
        bif.LD_REG = 1'b0;
        bif.LD_CC  = 1'b0;
        bif.LD_BEN = 1'b0;
        bif.MIO_EN = 1'b0;
        bif.PCMUX  = 2'b11;
        bif.DRMUX  = 1'b0;
        bif.SR1MUX = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] v);
        clear_ctrl();
        bif.bus   = v;
        bif.LD_IR = 1'b1;
        step();
        clear_ctrl();
    endtask

    task automatic test_reset();
        bif.bus = 16'hBEEF; bif.mdr_in = 16'hBEEF; bif.addr_sum = 16'hBEEF;
        bif.LD_MAR = 1; bif.LD_MDR = 1; bif.LD_IR = 1; bif.LD_PC = 1;
        bif.LD_REG = 1; bif.LD_CC = 1; bif.LD_BEN = 1;
        bif.MIO_EN = 1; bif.PCMUX = 2'b01; bif.DRMUX = 0; bif.SR1MUX = 0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        clear_ctrl();
        vectors++;
        if ({bif.MAR, bif.MDR, bif.IR, bif.PC} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h %h %h %h expected all 0000", bif.MAR, bif.MDR, bif.IR, bif.PC);
        end
        vectors++;
        if ({bif.sr1_out, bif.sr2_out, bif.nzp, bif.BEN} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_flags: sr1=%h sr2=%h nzp=%b ben=%b expected zeros", bif.sr1_out, bif.sr2_out, bif.nzp, bif.BEN);
        end
        for (int i = 0; i < 8; i++) exp_reg[i] = 16'h0000;
    endtask

    task automatic test_regfile();
        load_ir(16'h1A42);
        vectors++;
        if (bif.IR !== 16'h1A42) begin
            miscompares++;
            $display("FAIL ir_load: got %h expected 1a42", bif.IR);
        end
        bif.bus = 16'h8001; bif.LD_REG = 1; bif.DRMUX = 0;
        step();
        clear_ctrl();
        exp_reg[5] = 16'h8001;
        vectors++;
        if (bif.sr1_out !== 16'h8001) begin
            miscompares++;
            $display("FAIL sr1_r5: got %h expected 8001", bif.sr1_out);
        end
        vectors++;
        if (bif.sr2_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL sr2_r2: got %h expected 0000", bif.sr2_out);
        end
        bif.SR1MUX = 1; #1;
        vectors++;
        if (bif.sr1_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL sr1mux_r1: got %h expected 0000", bif.sr1_out);
        end
        // read-during-write: old value until the edge
        bif.SR1MUX = 0; bif.bus = 16'h4444; bif.LD_REG = 1;
        @(negedge Clk);
        vectors++;
        if (bif.sr1_out !== 16'h8001) begin
            miscompares++;
            $display("FAIL rdw_before: got %h expected 8001", bif.sr1_out);
        end
        step();
        clear_ctrl();
        exp_reg[5] = 16'h4444;
        vectors++;
        if (bif.sr1_out !== 16'h4444) begin
            miscompares++;
            $display("FAIL rdw_after: got %h expected 4444", bif.sr1_out);
        end
    endtask

    task automatic test_cc();
        logic [15:0] cc_bus [3];
        logic [2:0]  cc_exp [3];
        cc_bus[0] = 16'h8000; cc_exp[0] = 3'b100;
        cc_bus[1] = 16'h0000; cc_exp[1] = 3'b010;
        cc_bus[2] = 16'h0001; cc_exp[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            bif.bus = cc_bus[i]; bif.LD_CC = 1;
            step();
            vectors++;
            if (bif.nzp !== cc_exp[i]) begin
                miscompares++;
                $display("FAIL nzp_%0d: got %b expected %b", i, bif.nzp, cc_exp[i]);
            end
        end
        clear_ctrl();
        bif.bus = 16'h8000;
        step();
        vectors++;
        if (bif.nzp !== 3'b001) begin
            miscompares++;
            $display("FAIL nzp_hold: got %b expected 001", bif.nzp);
        end
    endtask

    task automatic test_pc();
        logic [1:0]  sel [5];
        logic        ld  [5];
        logic [15:0] exp [5];
        sel[0] = 2'b01; ld[0] = 1; exp[0] = 16'hFFFF;
        sel[1] = 2'b00; ld[1] = 1; exp[1] = 16'h0000;
        sel[2] = 2'b10; ld[2] = 1; exp[2] = 16'h3000;
        sel[3] = 2'b11; ld[3] = 1; exp[3] = 16'h3000;
        sel[4] = 2'b00; ld[4] = 0; exp[4] = 16'h3000;
        bif.bus = 16'hFFFF; bif.addr_sum = 16'h3000;
        for (int i = 0; i < 5; i++) begin
            bif.PCMUX = sel[i]; bif.LD_PC = ld[i];
            step();
            vectors++;
            if (bif.PC !== exp[i]) begin
                miscompares++;
                $display("FAIL pc_%0d: got %h expected %h", i, bif.PC, exp[i]);
            end
        end
        clear_ctrl();
    endtask

    task automatic test_ben();
        load_ir(16'h0400);
        bif.bus = 16'h0000; bif.LD_CC = 1;
        step();
        bif.bus = 16'hFFFF; bif.LD_CC = 1; bif.LD_BEN = 1;
        step();
        clear_ctrl();
        vectors++;
        if (bif.BEN !== 1'b1 || bif.nzp !== 3'b100) begin
            miscompares++;
            $display("FAIL ben_old_nzp: got ben=%b nzp=%b expected ben=1 nzp=100", bif.BEN, bif.nzp);
        end
        bif.LD_BEN = 1;
        step();
        vectors++;
        if (bif.BEN !== 1'b0) begin
            miscompares++;
            $display("FAIL ben_clear: got %b expected 0", bif.BEN);
        end
        // IR switches to [11:9]=100 in the same cycle: BEN must still see the old 010
        bif.bus = 16'h0800; bif.LD_IR = 1; bif.LD_BEN = 1;
        step();
        clear_ctrl();
        vectors++;
        if (bif.BEN !== 1'b0) begin
            miscompares++;
            $display("FAIL ben_old_ir: got %b expected 0", bif.BEN);
        end
        bif.LD_BEN = 1;
        step();
        clear_ctrl();
        vectors++;
        if (bif.BEN !== 1'b1) begin
            miscompares++;
            $display("FAIL ben_new_ir: got %b expected 1", bif.BEN);
        end
    endtask

    task automatic test_mdr_mar();
        bif.mdr_in = 16'h1234; bif.bus = 16'h5678;
        bif.LD_MDR = 1; bif.MIO_EN = 1; bif.LD_MAR = 1;
        step();
        vectors++;
        if (bif.MDR !== 16'h1234 || bif.MAR !== 16'h5678) begin
            miscompares++;
            $display("FAIL mdr_mem: got mdr=%h mar=%h expected 1234 5678", bif.MDR, bif.MAR);
        end
        bif.MIO_EN = 0; bif.LD_MAR = 0; bif.bus = 16'h5679;
        step();
        clear_ctrl();
        vectors++;
        if (bif.MDR !== 16'h5679 || bif.MAR !== 16'h5678) begin
            miscompares++;
            $display("FAIL mdr_bus: got mdr=%h mar=%h expected 5679 5678", bif.MDR, bif.MAR);
        end
    endtask

    task automatic test_back_to_back();
        // IR currently 0x0800 -> DR=4; DRMUX=1 must still go to R7
        bif.bus = 16'h7777; bif.LD_REG = 1; bif.DRMUX = 1;
        step();
        clear_ctrl();
        exp_reg[7] = 16'h7777;
        load_ir(16'h0400);
        // LD_IR + LD_REG together: destination is the old IR[11:9]=2, not the new 7
        bif.bus = 16'h0E03; bif.LD_IR = 1; bif.LD_REG = 1;
        step();
        clear_ctrl();
        exp_reg[2] = 16'h0E03;
        bif.bus = 16'h0101; bif.LD_REG = 1;
        step();
        bif.bus = 16'h0202; bif.LD_REG = 1; bif.DRMUX = 1;
        step();
        clear_ctrl();
        exp_reg[7] = 16'h0202;
        vectors++;
        if (bif.IR !== 16'h0E03) begin
            miscompares++;
            $display("FAIL ir_with_reg: got %h expected 0e03", bif.IR);
        end
    endtask

    task automatic test_regfile_readback();
        for (int i = 0; i < 8; i++) begin
            load_ir({13'h0000, i[2:0]});
            vectors++;
            if (bif.sr2_out !== exp_reg[i]) begin
                miscompares++;
                $display("FAIL reg_r%0d: got %h expected %h", i, bif.sr2_out, exp_reg[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bif.bus = 16'hAAAA; bif.mdr_in = 16'h5555;
        bif.LD_MAR = 1; bif.LD_MDR = 1; bif.LD_PC = 1; bif.PCMUX = 2'b01;
        bif.LD_REG = 1; bif.LD_CC = 1; bif.LD_BEN = 1; bif.LD_IR = 1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        clear_ctrl();
        for (int i = 0; i < 8; i++) exp_reg[i] = 16'h0000;
        vectors++;
        if ({bif.MAR, bif.MDR, bif.IR, bif.PC, bif.nzp, bif.BEN} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_mid: mar=%h mdr=%h ir=%h pc=%h nzp=%b ben=%b expected zeros",
                     bif.MAR, bif.MDR, bif.IR, bif.PC, bif.nzp, bif.BEN);
        end
    endtask

    initial begin
        Reset = 1'b0;
        bif.bus = 16'h0; bif.mdr_in = 16'h0; bif.addr_sum = 16'h0;
        clear_ctrl();
        test_reset();
        test_regfile();
        test_cc();
        test_pc();
        test_ben();
        test_mdr_mar();
        test_back_to_back();
        test_regfile_readback();
        test_reset_mid();
        test_regfile_readback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
